// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: datapath selects and enables, a ready/ack memory handshake with
// bus timeout, a one-cycle TRAP state, and wrap-around cycle / retired-instruction counters.
module multicycle_control_unit #(
    parameter int TIMEOUT         = 16,
    parameter int CNT_WIDTH       = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           instruction_opcode,
    input  logic                 memory_ack,
    output logic                 lorD,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 memory_read,
    output logic                 memory_write,
    output logic                 memory_to_reg,
    output logic                 is_immediate,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic [1:0]           aluop,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 trap,
    output logic [3:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count,
    output logic [3:0]           debug_state
);

    localparam int WW = $clog2(TIMEOUT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_JALR_PC,
        S_JALR, S_AUIPC, S_LUI, S_TRAP
    } state_t;

    state_t                 state_q, state_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [3:0]             trap_cause_q, trap_cause_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;
    logic                   timed_out;
    logic                   retire;

    // Fault fires in the TIMEOUT-th cycle of a request when ack is still low; ack in that cycle wins.
    assign timed_out = (wait_q == WW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        trap_cause_d  = trap_cause_q;
        retire        = 1'b0;
        lorD          = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        memory_to_reg = 1'b0;
        is_immediate  = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        aluop         = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        trap          = 1'b0;

        case (state_q)
            S_FETCH: begin
                memory_read = 1'b1;
                alu_src_b   = 2'b01;
                if (memory_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (instruction_opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JALR:           state_d = S_JALR_PC;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_LUI:            state_d = S_LUI;
                    OP_FENCE: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_SYSTEM: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 4'd11;
                    end
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d      = S_TRAP;
                            trap_cause_d = 4'd2;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (instruction_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                memory_read = 1'b1;
                lorD        = 1'b1;
                if (memory_ack) begin
                    state_d = S_MEMWB;
                end else if (timed_out) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd5;
                end
            end
            S_MEMWB: begin
                reg_write     = 1'b1;
                memory_to_reg = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                memory_write = 1'b1;
                lorD         = 1'b1;
                if (memory_ack) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd7;
                end
            end
            S_EXECUTER: begin
                alu_src_a = 2'b01;
                aluop     = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                aluop        = 2'b10;
                is_immediate = 1'b1;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL, S_JALR: begin
                pc_write  = 1'b1;
                pc_source = 2'b01;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a     = 2'b01;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JALR_PC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_JALR;
            end
            S_AUIPC: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                trap      = 1'b1;
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Only request states can stay put, so any transition restarts the wait count.
        wait_d    = (state_d == state_q) ? wait_q + WW'(1) : '0;
        cycle_d   = cycle_q + CNT_WIDTH'(1);
        instret_d = instret_q + CNT_WIDTH'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            trap_cause_q <= '0;
            cycle_q      <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
        end
    end

    assign trap_cause    = trap_cause_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
    assign debug_state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level reference model expands each instruction
// into its expected per-cycle phases, drives memory_ack from that plan and checks every cycle.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: TIMEOUT 16, 32-bit counters, illegal opcodes trap.
    logic        reset_a = 1'b1, ack_a = 1'b0;
    logic [6:0]  opc_a = '0;
    logic [17:0] outs_a;
    logic [3:0]  cause_a, dbg_a;
    logic [31:0] cyc_a, ins_a;

    // Instance B: TIMEOUT 4, 4-bit counters, illegal opcodes are NOPs.
    logic        reset_b = 1'b1, ack_b = 1'b0;
    logic [6:0]  opc_b = '0;
    logic [17:0] outs_b;
    logic [3:0]  cause_b, dbg_b;
    logic [3:0]  cyc_b, ins_b;

    multicycle_control_unit #(.TIMEOUT(16), .CNT_WIDTH(32), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset_a), .instruction_opcode(opc_a), .memory_ack(ack_a),
        .lorD(outs_a[17]), .pc_write(outs_a[16]), .ir_write(outs_a[15]), .reg_write(outs_a[14]),
        .memory_read(outs_a[13]), .memory_write(outs_a[12]), .memory_to_reg(outs_a[11]),
        .is_immediate(outs_a[10]), .pc_write_cond(outs_a[9]), .pc_source(outs_a[8:7]),
        .aluop(outs_a[6:5]), .alu_src_a(outs_a[4:3]), .alu_src_b(outs_a[2:1]), .trap(outs_a[0]),
        .trap_cause(cause_a), .cycle_count(cyc_a), .instret_count(ins_a), .debug_state(dbg_a)
    );

    multicycle_control_unit #(.TIMEOUT(4), .CNT_WIDTH(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .instruction_opcode(opc_b), .memory_ack(ack_b),
        .lorD(outs_b[17]), .pc_write(outs_b[16]), .ir_write(outs_b[15]), .reg_write(outs_b[14]),
        .memory_read(outs_b[13]), .memory_write(outs_b[12]), .memory_to_reg(outs_b[11]),
        .is_immediate(outs_b[10]), .pc_write_cond(outs_b[9]), .pc_source(outs_b[8:7]),
        .aluop(outs_b[6:5]), .alu_src_a(outs_b[4:3]), .alu_src_b(outs_b[2:1]), .trap(outs_b[0]),
        .trap_cause(cause_b), .cycle_count(cyc_b), .instret_count(ins_b), .debug_state(dbg_b)
    );

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECUTER, P_EXECUTEI,
        P_ALUWB, P_JAL, P_BEQ, P_JALR_PC, P_JALR, P_AUIPC, P_LUI, P_TRAP
    } ph_t;

    typedef struct packed {
        logic        ack;
        logic        retire;
        logic        trap_ent;
        logic [3:0]  cause;
        logic [17:0] outs;
    } rec_t;

    rec_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_cyc[2];
    int unsigned m_ins[2];
    logic [3:0]  m_cause[2];
    logic [6:0]  known_ops[11] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH, OP_JALR,
                                   OP_AUIPC, OP_LUI, OP_FENCE, OP_SYSTEM};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] pack_o(logic lord, logic pcw, logic irw, logic rw, logic mr,
                                           logic mw, logic m2r, logic imm, logic pwc,
                                           logic [1:0] pcs, logic [1:0] aop, logic [1:0] asa,
                                           logic [1:0] asb, logic trp);
        return {lord, pcw, irw, rw, mr, mw, m2r, imm, pwc, pcs, aop, asa, asb, trp};
    endfunction

    // Expected enables/selects for each phase of an instruction.
    function automatic logic [17:0] outs_of(ph_t p, logic ack);
        case (p)
            P_FETCH:    return pack_o(0, ack, ack, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0);
            P_DECODE:   return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 0);
            P_MEMADR:   return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0);
            P_MEMREAD:  return pack_o(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            P_MEMWB:    return pack_o(0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            P_MEMWRITE: return pack_o(1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            P_EXECUTER: return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
            P_EXECUTEI: return pack_o(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
            P_ALUWB:    return pack_o(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            P_JAL:      return pack_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 0);
            P_BEQ:      return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01, 2'b00, 0);
            P_JALR_PC:  return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0);
            P_JALR:     return pack_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 0);
            P_AUIPC:    return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 0);
            P_LUI:      return pack_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b10, 0);
            default:    return pack_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 1);
        endcase
    endfunction

    function automatic void push_one(ph_t p, logic ack, logic retire, logic [3:0] cause);
        rec_t r;
        r.ack      = ack;
        r.retire   = retire;
        r.trap_ent = (p == P_TRAP);
        r.cause    = cause;
        r.outs     = outs_of(p, ack);
        exp_q.push_back(r);
    endfunction

    function automatic void push_plain(ph_t p, logic retire);
        push_one(p, 1'($urandom_range(0, 1)), retire, 4'd0);
    endfunction

    // A request phase: w wait cycles then ack, or a fault after tmo unanswered cycles.
    function automatic bit push_req(ph_t p, int w, int tmo, logic [3:0] cause);
        if (w >= tmo) begin
            for (int i = 0; i < tmo; i++) push_one(p, 1'b0, 1'b0, 4'd0);
            push_one(P_TRAP, 1'($urandom_range(0, 1)), 1'b0, cause);
            return 1'b1;
        end
        for (int i = 0; i < w; i++) push_one(p, 1'b0, 1'b0, 4'd0);
        push_one(p, 1'b1, (p == P_MEMWRITE), 4'd0);
        return 1'b0;
    endfunction

    function automatic void build(int sel, logic [6:0] opc, int wf, int wm);
        int tmo;
        bit til;
        tmo = (sel == 0) ? 16 : 4;
        til = (sel == 0);
        exp_q.delete();
        if (push_req(P_FETCH, wf, tmo, 4'd1)) return;
        push_plain(P_DECODE, opc == OP_FENCE);
        case (opc)
            OP_LOAD: begin
                push_plain(P_MEMADR, 0);
                if (!push_req(P_MEMREAD, wm, tmo, 4'd5)) push_plain(P_MEMWB, 1);
            end
            OP_STORE: begin
                push_plain(P_MEMADR, 0);
                void'(push_req(P_MEMWRITE, wm, tmo, 4'd7));
            end
            OP_R:      begin push_plain(P_EXECUTER, 0); push_plain(P_ALUWB, 1); end
            OP_I:      begin push_plain(P_EXECUTEI, 0); push_plain(P_ALUWB, 1); end
            OP_JAL:    begin push_plain(P_JAL, 0); push_plain(P_ALUWB, 1); end
            OP_BRANCH: push_plain(P_BEQ, 1);
            OP_JALR: begin
                push_plain(P_JALR_PC, 0);
                push_plain(P_JALR, 0);
                push_plain(P_ALUWB, 1);
            end
            OP_AUIPC:  begin push_plain(P_AUIPC, 0); push_plain(P_ALUWB, 1); end
            OP_LUI:    begin push_plain(P_LUI, 0); push_plain(P_ALUWB, 1); end
            OP_FENCE:  ;
            OP_SYSTEM: push_one(P_TRAP, 1'($urandom_range(0, 1)), 1'b0, 4'd11);
            default:   if (til) push_one(P_TRAP, 1'($urandom_range(0, 1)), 1'b0, 4'd2);
        endcase
    endfunction

    task automatic drive(input int sel, input logic rst, input logic ack, input logic [6:0] opc);
        if (sel == 0) begin reset_a = rst; ack_a = ack; opc_a = opc; end
        else          begin reset_b = rst; ack_b = ack; opc_b = opc; end
    endtask

    task automatic do_reset(input int sel, input int n);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, 7'd0);
        repeat (n) @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 7'd0);
        m_cyc[sel]   = 0;
        m_ins[sel]   = 0;
        m_cause[sel] = 4'd0;
    endtask

    // Executes the queued plan; cut > 0 stops after that many cycles (for a mid-instruction reset).
    task automatic run_plan(input int sel, input logic [6:0] opc, input int cut);
        rec_t        r;
        int          done;
        logic [31:0] mask, g_outs, g_cyc, g_ins, g_cause;
        done = 0;
        mask = (sel == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
        while (exp_q.size() > 0) begin
            if (cut > 0 && done == cut) begin
                exp_q.delete();
                break;
            end
            r = exp_q.pop_front();
            @(negedge clk);
            drive(sel, 1'b0, r.ack, opc);
            #1;
            if (r.trap_ent) m_cause[sel] = r.cause;
            g_outs  = (sel == 0) ? 32'(outs_a) : 32'(outs_b);
            g_cyc   = (sel == 0) ? cyc_a : 32'(cyc_b);
            g_ins   = (sel == 0) ? ins_a : 32'(ins_b);
            g_cause = (sel == 0) ? 32'(cause_a) : 32'(cause_b);
            check_eq($sformatf("outs[%0d] op=%b", sel, opc), g_outs, 32'(r.outs));
            check_eq($sformatf("cycle_count[%0d]", sel), g_cyc, m_cyc[sel] & mask);
            check_eq($sformatf("instret_count[%0d]", sel), g_ins, m_ins[sel] & mask);
            check_eq($sformatf("trap_cause[%0d]", sel), g_cause, 32'(m_cause[sel]));
            m_cyc[sel] = m_cyc[sel] + 1;
            m_ins[sel] = m_ins[sel] + 32'(r.retire);
            done++;
        end
    endtask

    task automatic run_instr(input int sel, input logic [6:0] opc, input int wf, input int wm);
        build(sel, opc, wf, wm);
        run_plan(sel, opc, 0);
    endtask

    function automatic logic [6:0] rand_opcode();
        logic [6:0] op;
        bit         hit;
        if ($urandom_range(0, 5) != 0) return known_ops[$urandom_range(0, 10)];
        do begin
            op  = 7'($urandom);
            hit = 0;
            foreach (known_ops[i]) if (known_ops[i] == op) hit = 1;
        end while (hit);
        return op;
    endfunction

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
    endfunction

    initial begin
        do_reset(0, 2);
        run_instr(0, OP_I, 0, 0);
        run_instr(0, OP_LOAD, 3, 2);
        run_instr(0, OP_STORE, 0, 100);
        run_instr(0, 7'b1111111, 0, 0);
        run_instr(0, OP_SYSTEM, 1, 0);
        run_instr(0, OP_FENCE, 0, 0);
        run_instr(0, OP_R, 20, 0);
        run_instr(0, OP_LOAD, 0, 15);
        run_instr(0, OP_STORE, 2, 15);
        run_instr(0, OP_JALR, 0, 0);
        for (int i = 0; i < 60; i++) run_instr(0, rand_opcode(), rand_wait(), rand_wait());
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 7'd0);

        do_reset(1, 2);
        run_instr(1, 7'b1111111, 0, 0);
        run_instr(1, OP_STORE, 0, 20);
        for (int i = 0; i < 12; i++) run_instr(1, rand_opcode(), rand_wait(), rand_wait());
        build(1, OP_LOAD, 0, 3);
        run_plan(1, OP_LOAD, 4);
        do_reset(1, 1);
        run_instr(1, OP_BRANCH, 0, 0);
        run_instr(1, OP_LUI, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
